// File: rtl/roi_metering_pkg.sv
// Shared camera package: metering FSM states and default parameter constants.
package roi_metering_pkg;

  localparam int DEF_DATA_WIDTH    = 10;
  localparam int DEF_OUT_WIDTH     = 8;
  localparam int DEF_MAX_SIZE_LOG2 = 9;
  localparam int DEF_COORD_WIDTH   = 11;
  localparam int NUM_CH            = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } meter_state_e;

endpackage

// File: rtl/roi_metering_accumulator.sv
// Per-channel window sum; cleared at frame start, adds one pixel per enabled cycle.
module metering_accumulator #(
  parameter int DATA_WIDTH = 10,
  parameter int SUM_WIDTH  = 28
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  clear_in,
  input  logic                  enable_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [SUM_WIDTH-1:0]  sum_out
);

  logic [SUM_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_in)
      sum_d = '0;
    else if (enable_in)
      sum_d = sum_q + SUM_WIDTH'(data_in);
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/roi_metering.sv
// Square-window RGB averaging and saturation counting over one frame,
// with a ready/ack result handshake and sticky overrun flag.
module roi_metering
  import roi_metering_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
  parameter int MAX_SIZE_LOG2 = DEF_MAX_SIZE_LOG2,
  parameter int COORD_WIDTH   = DEF_COORD_WIDTH
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic [DATA_WIDTH-1:0]      red_data_in,
  input  logic [DATA_WIDTH-1:0]      green_data_in,
  input  logic [DATA_WIDTH-1:0]      blue_data_in,
  input  logic                       line_valid_in,
  input  logic                       frame_valid_in,
  input  logic [COORD_WIDTH-1:0]     x_start_in,
  input  logic [COORD_WIDTH-1:0]     y_start_in,
  input  logic [3:0]                 size_log2_in,
  input  logic [DATA_WIDTH-1:0]      saturate_threshold_in,
  input  logic                       metering_ack_in,
  output logic [OUT_WIDTH-1:0]       red_metering_out,
  output logic [OUT_WIDTH-1:0]       green_metering_out,
  output logic [OUT_WIDTH-1:0]       blue_metering_out,
  output logic [2*MAX_SIZE_LOG2:0]   saturated_count_out,
  output logic                       metering_ready_out,
  output logic                       overrun_out,
  output logic                       incomplete_out
);

  localparam int SUM_W  = DATA_WIDTH + 2*MAX_SIZE_LOG2;
  localparam int CNT_W  = 2*MAX_SIZE_LOG2 + 1;
  localparam int CW1    = COORD_WIDTH + 1;
  localparam int STAGES = 1;
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE_LOG2);

  meter_state_e state_q, state_d;

  logic                         fv_q, fv_d;
  logic                         lv_q, lv_d;
  logic [COORD_WIDTH-1:0]       x_q, x_d, y_q, y_d;
  logic [COORD_WIDTH-1:0]       x_start_q, x_start_d, y_start_q, y_start_d;
  logic [3:0]                   size_q, size_d;
  logic [DATA_WIDTH-1:0]        thr_q, thr_d;
  logic [CNT_W-1:0]             win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]             sat_cnt_q, sat_cnt_d;
  logic [STAGES:0]              vld_pipe_q, vld_pipe_d;
  logic [NUM_CH-1:0][OUT_WIDTH-1:0] meter_q, meter_d;
  logic [CNT_W-1:0]             sat_out_q, sat_out_d;
  logic                         ready_q, ready_d;
  logic                         overrun_q, overrun_d;
  logic                         incomplete_q, incomplete_d;

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] pix;
  logic [NUM_CH-1:0][SUM_W-1:0]      sum;

  logic           fv_rise, start, pix_vld, in_win, acc_en, sat_pix;
  logic           size_ok, result_ok;
  logic [CW1-1:0] side, x_ext, y_ext, xs_ext, ys_ext;
  logic [CNT_W-1:0] full_cnt;

  assign pix = {blue_data_in, green_data_in, red_data_in};

  assign fv_rise = frame_valid_in && !fv_q;
  assign start   = (state_q == ST_IDLE) && fv_rise;
  assign pix_vld = (state_q == ST_ACTIVE) && frame_valid_in && line_valid_in;

  // Window bounds compared one bit wider than coordinates so x_start+side never wraps.
  assign side   = CW1'(1) << size_q;
  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign xs_ext = {1'b0, x_start_q};
  assign ys_ext = {1'b0, y_start_q};
  assign in_win = (x_ext >= xs_ext) && (x_ext < xs_ext + side) &&
                  (y_ext >= ys_ext) && (y_ext < ys_ext + side);
  assign acc_en = pix_vld && in_win;

  always_comb begin
    sat_pix = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (pix[c] >= thr_q) sat_pix = 1'b1;
  end

  assign full_cnt  = CNT_W'(1) << {size_q, 1'b0};
  assign size_ok   = (size_q != 4'd0) && (size_q <= MAX_SZ);
  assign result_ok = size_ok && (win_cnt_q == full_cnt);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_acc
      metering_accumulator #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUM_WIDTH  (SUM_W)
      ) u_acc (
        .clock_in  (clock_in),
        .reset_in  (reset_in),
        .clear_in  (start),
        .enable_in (acc_en),
        .data_in   (pix[g]),
        .sum_out   (sum[g])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    fv_d         = frame_valid_in;
    lv_d         = lv_q;
    x_d          = x_q;
    y_d          = y_q;
    x_start_d    = x_start_q;
    y_start_d    = y_start_q;
    size_d       = size_q;
    thr_d        = thr_q;
    win_cnt_d    = win_cnt_q;
    sat_cnt_d    = sat_cnt_q;
    vld_pipe_d   = {vld_pipe_q[STAGES-1:0], 1'b0};
    meter_d      = meter_q;
    sat_out_d    = sat_out_q;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    incomplete_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fv_rise) begin
          state_d   = ST_ACTIVE;
          x_start_d = x_start_in;
          y_start_d = y_start_in;
          size_d    = size_log2_in;
          thr_d     = saturate_threshold_in;
          x_d       = '0;
          y_d       = '0;
          lv_d      = 1'b0;
          win_cnt_d = '0;
          sat_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (!frame_valid_in) begin
          state_d       = ST_DONE;
          vld_pipe_d[0] = result_ok;
          incomplete_d  = !result_ok;
        end else begin
          lv_d = line_valid_in;
          if (line_valid_in) begin
            x_d = x_q + COORD_WIDTH'(1);
          end else if (lv_q) begin
            x_d = '0;
            y_d = y_q + COORD_WIDTH'(1);
          end
          if (acc_en) begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
            if (sat_pix) sat_cnt_d = sat_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Sums and config stay frozen until the next frame start, so the result
    // stage can read them directly two edges after frame end.
    if (vld_pipe_q[STAGES]) begin
      for (int c = 0; c < NUM_CH; c++)
        meter_d[c] = OUT_WIDTH'((sum[c] >> {size_q, 1'b0}) >> (DATA_WIDTH - OUT_WIDTH));
      sat_out_d = sat_cnt_q;
      ready_d   = 1'b1;
      if (ready_q && !metering_ack_in) overrun_d = 1'b1;
    end else if (metering_ack_in) begin
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      // A frame already under way at reset release must not look like a rising edge.
      fv_q         <= 1'b1;
      lv_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      x_start_q    <= '0;
      y_start_q    <= '0;
      size_q       <= '0;
      thr_q        <= '0;
      win_cnt_q    <= '0;
      sat_cnt_q    <= '0;
      vld_pipe_q   <= '0;
      meter_q      <= '0;
      sat_out_q    <= '0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
      incomplete_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_q         <= fv_d;
      lv_q         <= lv_d;
      x_q          <= x_d;
      y_q          <= y_d;
      x_start_q    <= x_start_d;
      y_start_q    <= y_start_d;
      size_q       <= size_d;
      thr_q        <= thr_d;
      win_cnt_q    <= win_cnt_d;
      sat_cnt_q    <= sat_cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      meter_q      <= meter_d;
      sat_out_q    <= sat_out_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      incomplete_q <= incomplete_d;
    end
  end

  assign red_metering_out    = meter_q[0];
  assign green_metering_out  = meter_q[1];
  assign blue_metering_out   = meter_q[2];
  assign saturated_count_out = sat_out_q;
  assign metering_ready_out  = ready_q;
  assign overrun_out         = overrun_q;
  assign incomplete_out      = incomplete_q;

endmodule
